// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle divider.
// Contents: bus widths, FSM state encoding, ready/start level names,
// the iteration count, and a helper that takes an operand's magnitude.
package div_pkg;

  localparam int REG_W  = 32;   // RegBus
  localparam int DREG_W = 64;   // DoubleRegBus

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  // One quotient bit per iteration.
  localparam logic [5:0] DIV_ITERS = 6'd32;

  // Two's-complement magnitude when the operand is treated as signed and
  // is negative; otherwise the operand unchanged. 0x80000000 maps onto
  // itself, which is the correct unsigned magnitude.
  function automatic logic [REG_W-1:0] op_mag(input logic [REG_W-1:0] val,
                                              input logic             is_signed);
    op_mag = (is_signed && val[REG_W-1]) ? (~val + 1'b1) : val;
  endfunction

endpackage

// File: rtl/div_if.sv
// Execute-stage <-> divider bundle.
// Handshake: execute raises start_i together with the operands and keeps
// start_i high until it observes ready_o = 1; result_o is valid in every
// cycle ready_o = 1. Dropping start_i releases the divider, which clears
// ready_o and result_o on the following edge. annul_i aborts a divide that
// has not yet produced its result.
//   master : execute side (drives request, observes result)
//   slave  : divider side
// dbg_state_o exposes the divider FSM state for observation.
interface div_if;
  import div_pkg::*;

  logic              signed_div_i;
  logic [REG_W-1:0]  opdata1_i;
  logic [REG_W-1:0]  opdata2_i;
  logic              start_i;
  logic              annul_i;
  logic [DREG_W-1:0] result_o;
  logic              ready_o;
  div_state_e        dbg_state_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, dbg_state_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, dbg_state_o
  );

endinterface

// File: rtl/div.sv
// Multi-cycle 32-bit radix-2 restoring divider for DIV/DIVU.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - div_if.slave: signed_div_i, opdata1_i (dividend), opdata2_i
//          (divisor), start_i, annul_i in; result_o = {remainder, quotient},
//          ready_o and dbg_state_o out (all outputs registered).
// Latency: start sampled at E0, 32 iterations at E1..E32, result and ready
// loaded at E33. A zero divisor returns 0 with ready loaded at E1.
module div
  import div_pkg::*;
(
  input  logic clk,
  input  logic rst,
  div_if.slave bus
);

  div_state_e        state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  // {partial remainder, dividend being shifted out / quotient shifted in}
  logic [64:0]       wr_q, wr_d;
  logic [REG_W-1:0]  divisor_q, divisor_d;
  logic              neg_quot_q, neg_quot_d;
  logic              neg_rem_q, neg_rem_d;
  logic [DREG_W-1:0] result_q, result_d;
  logic              ready_q, ready_d;

  logic [REG_W-1:0]  dividend_mag;
  logic [REG_W-1:0]  divisor_mag;
  logic              borrow;
  logic [REG_W-1:0]  diff;
  logic [REG_W-1:0]  quot_fin;
  logic [REG_W-1:0]  rem_fin;

  assign dividend_mag = op_mag(bus.opdata1_i, bus.signed_div_i);
  assign divisor_mag  = op_mag(bus.opdata2_i, bus.signed_div_i);

  // The remainder lives in wr[63:32]; shifted left with the next dividend
  // bit it is wr[64:31]. The comparison keeps every bit so divisors at or
  // above 2^31 are handled. When no borrow occurs the difference is below
  // the divisor, so its low 32 bits are exact.
  assign borrow = (wr_q[64:31] < {2'b00, divisor_q});
  assign diff   = wr_q[62:31] - divisor_q;

  // Quotient sign is the XOR of operand signs; remainder follows dividend.
  assign quot_fin = neg_quot_q ? (~wr_q[31:0] + 1'b1)  : wr_q[31:0];
  assign rem_fin  = neg_rem_q  ? (~wr_q[63:32] + 1'b1) : wr_q[63:32];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    divisor_d  = divisor_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    ready_d    = ready_q;

    case (state_q)
      DivFree: begin
        result_d = '0;
        ready_d  = DIV_RESULT_NOT_READY;
        if (bus.start_i == DIV_START && !bus.annul_i) begin
          if (bus.opdata2_i == '0) begin
            state_d = DivByZero;
          end else begin
            divisor_d  = divisor_mag;
            wr_d       = {33'b0, dividend_mag};
            cnt_d      = '0;
            neg_quot_d = bus.signed_div_i & (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
            neg_rem_d  = bus.signed_div_i & bus.opdata1_i[31];
            state_d    = DivOn;
          end
        end
      end

      DivByZero: begin
        result_d = '0;
        if (bus.annul_i) begin
          ready_d = DIV_RESULT_NOT_READY;
          state_d = DivFree;
        end else begin
          ready_d = DIV_RESULT_READY;
          state_d = DivEnd;
        end
      end

      DivOn: begin
        if (bus.annul_i) begin
          result_d = '0;
          ready_d  = DIV_RESULT_NOT_READY;
          state_d  = DivFree;
        end else if (cnt_q != DIV_ITERS) begin
          if (borrow) begin
            wr_d = {wr_q[63:0], 1'b0};
          end else begin
            wr_d = {1'b0, diff, wr_q[30:0], 1'b1};
          end
          cnt_d = cnt_q + 6'd1;
        end else begin
          result_d = {rem_fin, quot_fin};
          ready_d  = DIV_RESULT_READY;
          state_d  = DivEnd;
        end
      end

      DivEnd: begin
        // annul_i is deliberately ignored here: the result is already done
        // and only the start drop releases the divider.
        if (bus.start_i == DIV_STOP) begin
          result_d = '0;
          ready_d  = DIV_RESULT_NOT_READY;
          state_d  = DivFree;
        end
      end

      default: begin
        result_d = '0;
        ready_d  = DIV_RESULT_NOT_READY;
        state_d  = DivFree;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DivFree;
      cnt_q      <= '0;
      wr_q       <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= DIV_RESULT_NOT_READY;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      divisor_q  <= divisor_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign bus.result_o    = result_q;
  assign bus.ready_o     = ready_q;
  assign bus.dbg_state_o = state_q;

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed corner cases plus random divides
// against an arithmetic reference model, with a scoreboard queue consumed
// by a monitor that fires on every rising ready_o.
module tb_div;
  import div_pkg::*;

  logic clk;
  logic rst;
  div_if bus ();

  div u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    q = sa / sb;   // truncates toward zero
    r = sa % sb;   // sign follows dividend
    return {r[31:0], q[31:0]};
  endfunction

  // ---------------- monitor ----------------
  logic prev_ready = 1'b0;
  always @(negedge clk) begin
    if (bus.ready_o === 1'b1 && prev_ready !== 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got result %h with no divide outstanding", bus.result_o);
      end else begin
        check("result", bus.result_o, exp_q.pop_front());
      end
    end
    prev_ready = bus.ready_o;
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
  endtask

  // Full transaction: issue at a negedge, scramble operands after E0, check
  // latency, release, and check the cleared outputs and idle state.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    int cyc;
    int exp_lat;
    exp_lat = (b == 32'd0) ? 2 : 34;
    exp_q.push_back(model(a, b, sgn));
    issue(a, b, sgn);
    cyc = 0;
    while (bus.ready_o !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      bus.opdata1_i    = $urandom;
      bus.opdata2_i    = $urandom;
      bus.signed_div_i = $urandom_range(0, 1);
    end
    check("latency", 64'(cyc), 64'(exp_lat));
    bus.start_i = 1'b0;
    @(negedge clk);
    check("ready_after_drop", {63'b0, bus.ready_o}, 64'd0);
    check("result_after_drop", bus.result_o, 64'd0);
    check("state_after_drop", {62'b0, bus.dbg_state_o}, {62'b0, DivFree});
  endtask

  task automatic check_idle(input string name);
    check({name, "_ready"}, {63'b0, bus.ready_o}, 64'd0);
    check({name, "_result"}, bus.result_o, 64'd0);
    check({name, "_state"}, {62'b0, bus.dbg_state_o}, {62'b0, DivFree});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a, b;
    logic        sgn;
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    @(negedge clk);

    // directed cases
    run_div(32'd100, 32'd7, 1'b0);
    run_div(32'hFFFF_FFF9, 32'h2, 1'b1);
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1);
    run_div(32'd5, 32'd0, 1'b0);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_div(32'hFFFF_FFFF, 32'h1, 1'b0);
    run_div(32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
    run_div(32'h1234_5678, 32'hFFFF_FFFF, 1'b0);

    // annul mid-divide
    issue(32'd1000, 32'd3, 1'b0);
    repeat (10) @(negedge clk);
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    @(negedge clk);
    bus.annul_i = 1'b0;
    check_idle("annul");
    repeat (2) @(negedge clk);
    run_div(32'd9, 32'd3, 1'b0);

    // reset mid-divide
    issue(32'hDEAD_BEEF, 32'd13, 1'b0);
    repeat (21) @(negedge clk);
    rst = 1'b1;
    bus.start_i = 1'b0;
    @(negedge clk);
    check_idle("mid_reset");
    rst = 1'b0;
    @(negedge clk);
    run_div(32'hDEAD_BEEF, 32'd13, 1'b0);

    // random divides
    for (int i = 0; i < 40; i++) begin
      sgn = $urandom_range(0, 1);
      a   = $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = -$urandom_range(1, 15);
        3:       b = 32'h8000_0000 | $urandom;
        default: b = $urandom;
      endcase
      run_div(a, b, sgn);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
